// File: rtl/rr_arbiter_vn_vc.sv
// rtl/rr_arbiter_vn_vc.sv - round-robin VN/VC arbiter with optional packet lock
// RR_ARB_PACKET_LOCK_EN: hold the grant on one requester until its tail flit is accepted.
module rr_arbiter_vn_vc #(
  parameter int NUM_VC = 1,
  parameter int NUM_VN = 3,
  localparam int N = NUM_VN * NUM_VC,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   request,
  input  logic [N-1:0]   tail,
  input  logic           advance,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id,
  output logic           locked
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] next_ptr;
  logic           rr_found;
  logic [IDW-1:0] rr_id;
  logic           sel_found;
  logic [IDW-1:0] sel_id;
  int             idx;
  logic [IDW-1:0] idx_v;

  // Scan ptr, ptr+1, ... wrapping at N; first requester wins.
  always_comb begin
    rr_found = 1'b0;
    rr_id    = '0;
    idx      = 0;
    idx_v    = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      idx_v = IDW'(idx);
      if (!rr_found && request[idx_v]) begin
        rr_found = 1'b1;
        rr_id    = idx_v;
      end
    end
  end

  assign next_ptr = (sel_id == IDW'(N - 1)) ? '0 : sel_id + 1'b1;

`ifdef RR_ARB_PACKET_LOCK_EN
  logic           lock;
  logic [IDW-1:0] lock_id;

  // While locked only the owner may be granted, even if it is momentarily idle.
  assign sel_found = lock ? request[lock_id] : rr_found;
  assign sel_id    = lock ? lock_id : rr_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      lock    <= 1'b0;
      lock_id <= '0;
    end else if (advance && sel_found) begin
      if (tail[sel_id]) begin
        lock <= 1'b0;
        ptr  <= next_ptr;
      end else begin
        lock    <= 1'b1;
        lock_id <= sel_id;
      end
    end
  end

  assign locked = lock;
`else
  logic unused_tail;

  assign sel_found   = rr_found;
  assign sel_id      = rr_id;
  assign unused_tail = ^tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && sel_found) begin
      ptr <= next_ptr;
    end
  end

  assign locked = 1'b0;
`endif

  always_comb begin
    grant = '0;
    if (sel_found) grant[sel_id] = 1'b1;
  end

  assign grant_valid = sel_found;
  assign grant_id    = sel_found ? sel_id : '0;

endmodule

// File: doc/rr_arbiter_vn_vc.md
# rr_arbiter_vn_vc

Round-robin arbiter over the NUM_VN × NUM_VC request vector of the network injector, replacing fixed-priority selection so that no virtual channel can be starved. It issues a one-hot grant plus encoded index, and holds the grant on one requester for a whole packet until its tail flit is accepted downstream. It sits between the per-VC injection queues and the output link multiplexer.

## Interface
- NUM_VC, 1, virtual channels per virtual network
- NUM_VN, 3, virtual networks
- Derived: N = NUM_VN*NUM_VC; IDW = Log2(N), minimum 1
- Requester index i = vn*NUM_VC + vc

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- request  in  N  bit i high = requester i has a flit ready
- tail  in  N  bit i high = requester i's current flit is the tail; only sampled for the granted index
- advance  in  1  downstream accepted the granted flit this cycle
- grant  out  N  one-hot grant, all-zero when none
- grant_valid  out  1  OR of grant
- grant_id  out  IDW  binary index of granted requester, 0 when grant_valid=0
- locked  out  1  a packet is in progress; grant is held on lock_id

## Operation
- State: ptr (IDW bits, next index with highest priority), lock (1 bit), lock_id (IDW bits).
- Unlocked selection: the first i with request[i]=1 scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (modulo N, ptr < N always).
- Locked selection: grant[lock_id] = request[lock_id]; no other bit may be granted even if requesting.
- On advance=1 with grant_valid=1 (granted index g):
  - tail[g]=1: lock<=0; ptr<=(g+1) mod N (wraps N-1→0).
  - tail[g]=0: lock<=1; lock_id<=g; ptr unchanged.
- advance=1 with grant_valid=0: ignored, no state change.
- Locked requester deasserts request: grant all-zero, lock/lock_id/ptr held; grant resumes on same index when request returns.
- Single-flit packet (tail=1 on first accepted flit): never locks; ptr advances.
- N=1: ptr stays 0; grant = request.

## Timing
- Reset (async assert, synchronous-safe deassert at top level): ptr=0, lock=0, lock_id=0. Outputs then combinational: locked=0; grant/grant_valid/grant_id track request with index 0 highest priority.
- grant, grant_valid, grant_id: combinational from request and registered state, same-cycle (zero latency).
- ptr/lock/lock_id update on the rising clk edge where advance=1 && grant_valid=1; new priority visible the following cycle.
- locked: registered, equals lock.
- Reset mid-packet: lock cleared immediately; next packet starts from index 0 priority; partial packet is the injector's responsibility.
- request changes between cycles while unlocked: re-arbitrated freely each cycle; no state change without advance.

## Configuration
- Macro RR_ARB_PACKET_LOCK_EN.
- Defined: packet locking as above (grant held until tail accepted).
- Undefined: flit-level round-robin; lock and lock_id are not implemented, locked tied 0, tail ignored; every accepted flit sets ptr<=(g+1) mod N.

## Test plan
- NUM_VC=2, NUM_VN=3 (N=6), reset, request=6'b111111, advance=1 and tail=all-ones every cycle -> grant_id sequence 0,1,2,3,4,5,0; locked stays 0.
- N=6, macro defined, request=6'b000101, tail=0 for three accepted flits then tail[0]=1 -> grant_id=0 for four cycles, locked=1 from cycle 2 to 4, then grant_id=2, ptr=1.
- Locked on index 3, request[3] drops for 2 cycles while request[1]=1 -> grant=0, grant_valid=0 those cycles; grant_id=3 on return.
- ptr=5 (after granting 4 with tail), request=6'b010001 -> grant_id=0 (wrap); after tail accepted, ptr=1 and next grant goes to 4.
- Assert rst_n=0 mid-packet (locked=1, lock_id=4) -> locked=0 immediately; after release with request=6'b010001, grant_id=0.
- Macro undefined, request=6'b000011, tail=0 always, advance=1 -> grant_id alternates 0,1,0,1; locked=0.
